// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop counter slice.
// Holds the 2-bit {J,K} command encoding and the excitation helper that
// turns a (current, next) bit pair into the JK command that produces it.
package jk_pkg;

    // {J,K} command encoding understood by jk_cell
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Returns {J,K} that moves a cell from cur to nxt:
    // J = nxt & ~cur, K = ~nxt & cur. A bit that keeps its value is held,
    // so toggle is never requested by this mapping even though cells support it.
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        logic [1:0] cmd;
        cmd = JK_HOLD;
        if (cur != nxt) begin
            cmd = nxt ? JK_SET : JK_RESET;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with synchronous active-high reset.
// Commands: 00 hold, 01 reset, 10 set, 11 toggle (never undefined).
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    // State flop: reset wins, otherwise apply the JK command
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MOD up/down counter built from WIDTH jk_cell instances.
// The next state is computed here, translated into per-bit J/K commands and
// applied to the cells. tc is combinational and meant to drive the en of a
// cascaded stage.
// Optional feature: define JKCNT_OVF_STICKY_EN to make ovf a sticky wrap flag;
// without it ovf is tied low and no flop is built.
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // Largest legal count, and the modulus widened by one bit so that a
    // modulus equal to 2**WIDTH can still be compared against d.
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] load_val;
    logic             at_last;
    logic             at_zero;

    assign at_last = (q == LAST);
    assign at_zero = (q == '0);

    // Load value saturates at MOD-1 so q never leaves the count sequence
    always_comb begin
        load_val = d;
        if ({1'b0, d} >= MOD_EXT) begin
            load_val = LAST;
        end
    end

    // Next state: load beats counting, counting wraps at both ends, otherwise hold.
    // Reset is handled inside the cells themselves, so it is not folded in here.
    always_comb begin
        nq = q;
        if (load) begin
            nq = load_val;
        end else if (en) begin
            if (up) begin
                nq = at_last ? '0 : q + WIDTH'(1);
            end else begin
                nq = at_zero ? LAST : q - WIDTH'(1);
            end
        end
    end

    // Per-bit excitation derived from the current and next state
    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j[i], k[i]} = jk_excite(q[i], nq[i]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .clk (clk),
                .rst (rst),
                .j   (j[gi]),
                .k   (k[gi]),
                .q   (q[gi])
            );
        end
    endgenerate

    assign tc = en & ~load & ((up & at_last) | (~up & at_zero));

`ifdef JKCNT_OVF_STICKY_EN
    logic ovf_r;

    // Sticky wrap flag: set on any counting edge that wraps, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (tc) begin
            ovf_r <= 1'b1;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench for jk_sync_counter (WIDTH=4, MOD=10) plus a two-stage
// cascade of modulo-16 counters. Expected values come from an integer model.
module tb_jk_sync_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

`ifdef JKCNT_OVF_STICKY_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic         tc;
    logic         ovf;

    logic         cas_rst = 1'b1;
    logic         cas_en = 1'b0;
    logic [3:0]   lo_q;
    logic [3:0]   hi_q;
    logic         lo_tc;
    logic         hi_tc;
    logic         lo_ovf;
    logic         hi_ovf;

    int  compare_count = 0;
    int  fail_count = 0;
    int  model_q = 0;
    bit  model_ovf = 1'b0;
    bit  model_valid = 1'b0;
    int  cas_model = 0;

    always #5 clk = ~clk;

    jk_sync_counter #(.WIDTH(W), .MOD(MOD)) dut (
        .clk (clk), .rst (rst), .en (en), .up (up), .load (load),
        .d (d), .q (q), .tc (tc), .ovf (ovf)
    );

    jk_sync_counter #(.WIDTH(4), .MOD(16)) cas_lo (
        .clk (clk), .rst (cas_rst), .en (cas_en), .up (1'b1), .load (1'b0),
        .d (4'h0), .q (lo_q), .tc (lo_tc), .ovf (lo_ovf)
    );

    jk_sync_counter #(.WIDTH(4), .MOD(16)) cas_hi (
        .clk (clk), .rst (cas_rst), .en (lo_tc), .up (1'b1), .load (1'b0),
        .d (4'h0), .q (hi_q), .tc (hi_tc), .ovf (hi_ovf)
    );

    // One comparison with failure counting and reporting
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compare_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of controls, check tc before the edge and q/ovf after it
    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [W-1:0] dv);
        bit exp_tc;
        bit wrap;
        @(negedge clk);
        rst = r; en = e; up = u; load = l; d = dv;
        #1;
        wrap = 1'b0;
        if (model_valid) begin
            exp_tc = e && !l && ((u && model_q == MOD - 1) || (!u && model_q == 0));
            checkOutput("tc", {7'd0, tc}, {7'd0, exp_tc});
            wrap = exp_tc;
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_q = 0;
            model_ovf = 1'b0;
            model_valid = 1'b1;
        end else if (l) begin
            model_q = (int'(dv) >= MOD) ? MOD - 1 : int'(dv);
        end else if (e) begin
            model_q = u ? (model_q + 1) % MOD : (model_q + MOD - 1) % MOD;
            if (wrap) model_ovf = 1'b1;
        end
        if (model_valid) begin
            checkOutput("q", {4'd0, q}, 8'(model_q));
            checkOutput("ovf", {7'd0, ovf}, {7'd0, model_ovf & OVF_ON});
        end
    endtask

    // One cascade cycle: 8-bit value model checked after every edge
    task automatic cascadeStep(input logic r, input logic e);
        @(negedge clk);
        cas_rst = r; cas_en = e;
        #1;
        if (!r) checkOutput("cas_lo_tc", {7'd0, lo_tc}, {7'd0, (e && (cas_model % 16) == 15)});
        @(posedge clk);
        #1;
        if (r) cas_model = 0;
        else if (e) cas_model = (cas_model + 1) % 256;
        checkOutput("cas_value", {hi_q, lo_q}, 8'(cas_model));
    endtask

    initial begin
        // Reset, then count up through the wrap
        applyStimulus(1, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 0);

        // Down wrap from zero
        applyStimulus(0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);

        // Load priority, saturation, reset over load
        applyStimulus(0, 1, 1, 1, 4);
        applyStimulus(0, 1, 1, 1, 12);
        applyStimulus(0, 1, 0, 1, 15);
        applyStimulus(1, 1, 1, 1, 7);

        // Hold at 5 while up toggles, then direction changes
        applyStimulus(0, 0, 1, 1, 5);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);

        // Reset mid-count at 7, then resume
        applyStimulus(0, 1, 1, 1, 7);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom),
                          ($urandom_range(0, 7) == 0),
                          4'($urandom));
        end

        // Cascade: reset, then count 20 edges, then a long run across hi wraps
        cascadeStep(1, 0);
        for (int i = 0; i < 20; i++) cascadeStep(0, 1);
        cascadeStep(0, 0);
        for (int i = 0; i < 260; i++) cascadeStep(0, 1'($urandom_range(0, 7) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
